// File: rtl/mac2_sequencer_pkg.sv
// rtl/mac2_sequencer_pkg.sv - shared types and constants for the MAC2 sequencer
// Purpose: FSM state encoding, default pipeline latencies and MAC output width.
// Ports: none (package).
package mac2_sequencer_pkg;

  localparam int MEM_LAT_DEF  = 1;
  localparam int MULT_LAT_DEF = 1;
  localparam int MAC_W        = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_ISSUE,
    S_DRAIN,
    S_CAPTURE,
    S_HOLD
  } state_t;

endpackage

// File: rtl/mac2_sequencer_valid_delay_line.sv
// rtl/mac2_sequencer_valid_delay_line.sv - valid-bit delay line aligning accumulate strobes
// Purpose: delays a 1-bit valid by DEPTH cycles.
// Ports:
//   clk, rst_n     clock, asynchronous active-low clear
//   valid_i        valid entering the pipeline
//   valid_o        valid leaving the pipeline, DEPTH cycles later
//   tail_empty_o   no valid bit behind the output stage (only valid_o may still be high)
module mac2_sequencer_valid_delay_line #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic valid_i,
  output logic valid_o,
  output logic tail_empty_o
);

  // sr_q[DEPTH-1] takes the input, sr_q[0] is the output stage.
  logic [DEPTH-1:0] sr_q;

  generate
    if (DEPTH == 1) begin : g_one
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sr_q <= 1'b0;
        else        sr_q <= valid_i;
      end
      assign tail_empty_o = 1'b1;
    end else begin : g_multi
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sr_q <= '0;
        else        sr_q <= {valid_i, sr_q[DEPTH-1:1]};
      end
      assign tail_empty_o = (sr_q[DEPTH-1:1] == '0);
    end
  endgenerate

  assign valid_o = sr_q[0];

endmodule

// File: rtl/mac2_sequencer.sv
// rtl/mac2_sequencer.sv - control sequencer feeding the MAC2 neuron datapath
// Purpose: on start, loads bias, issues N operand reads, strobes accumulate
// as each product leaves the memory+multiplier pipeline, then captures and
// holds the accumulator under a valid/ready handshake.
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   start, n_terms          job request and product count (clamped to 2**ADDR_W)
//   busy                    job in progress
//   mem_rd_en, mem_addr     operand memory read strobe and pair index
//   mac_init, mac_ld_reg    MAC2 bias load / accumulate strobes
//   mac_inc                 reserved, tied low
//   mac_out                 MAC2 accumulator value
//   result, result_valid, result_ready   captured result handshake
module mac2_sequencer
  import mac2_sequencer_pkg::*;
#(
  parameter int ADDR_W   = 4,
  parameter int MEM_LAT  = MEM_LAT_DEF,
  parameter int MULT_LAT = MULT_LAT_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W:0]   n_terms,
  output logic              busy,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mac_init,
  output logic              mac_ld_reg,
  output logic              mac_inc,
  input  logic [MAC_W-1:0]  mac_out,
  output logic [MAC_W-1:0]  result,
  output logic              result_valid,
  input  logic              result_ready
);

  localparam int L = MEM_LAT + MULT_LAT;
  localparam logic [ADDR_W:0] MAX_TERMS = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] ONE       = {{ADDR_W{1'b0}}, 1'b1};

  state_t            state_q, state_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [MAC_W-1:0]  result_q, result_d;
  logic [ADDR_W:0]   addr_nxt;
  logic              tail_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      addr_q   <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      result_q <= result_d;
    end
  end

  // Computed one bit wider so the last index of a full 2**ADDR_W job is detected.
  assign addr_nxt = {1'b0, addr_q} + ONE;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    result_d = result_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          cnt_d   = (n_terms > MAX_TERMS) ? MAX_TERMS : n_terms;
          state_d = S_INIT;
        end
      end
      S_INIT: begin
        addr_d  = '0;
        state_d = (cnt_q != '0) ? S_ISSUE : S_CAPTURE;
      end
      S_ISSUE: begin
        addr_d = addr_nxt[ADDR_W-1:0];
        if (addr_nxt == cnt_q) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        // Leave once only the final strobe (if any) remains: it accumulates
        // on this edge, so mac_out is settled during CAPTURE.
        if (tail_empty) state_d = S_CAPTURE;
      end
      S_CAPTURE: begin
        result_d = mac_out;
        state_d  = S_HOLD;
      end
      S_HOLD: begin
        if (result_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  mac2_sequencer_valid_delay_line #(
    .DEPTH (L)
  ) u_delay (
    .clk          (clk),
    .rst_n        (rst_n),
    .valid_i      (mem_rd_en),
    .valid_o      (mac_ld_reg),
    .tail_empty_o (tail_empty)
  );

  assign busy         = (state_q != S_IDLE);
  assign mac_init     = (state_q == S_INIT);
  assign mem_rd_en    = (state_q == S_ISSUE);
  assign mem_addr     = mem_rd_en ? addr_q : '0;
  assign mac_inc      = 1'b0;
  assign result       = result_q;
  assign result_valid = (state_q == S_HOLD);

endmodule
